// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART image loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR, BODY, CHK, DONE, ERR} loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 4;

endpackage

// File: rtl/rx_byte_edge.sv
// Turns the receiver's byte-ready level into a single-cycle byte strobe.
module rx_byte_edge (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       level_i,
  output logic       valid_o,
  output logic [7:0] byte_o
);

  logic rx_prev_q;

  // Resetting to 1 keeps a level that is already high at reset from counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) rx_prev_q <= 1'b1;
    else       rx_prev_q <= level_i;
  end

  // The strobe is combinational so the byte is consumed in its own edge cycle.
  assign valid_o = level_i & ~rx_prev_q;
  assign byte_o  = data_i;

endmodule

// File: rtl/uart_loader.sv
// Parses a word-count header and writes the following big-endian words to memory.
// Optional trailing XOR checksum byte: define UART_LOADER_CHECKSUM_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned     ADDR_W     = 15,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter longint unsigned MAX_WORDS  = 64'd1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_finished,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef UART_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CHK;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [31:0]       cnt_q, cnt_d, cnt_nx;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       idx_q, idx_d;
  logic [23:0]       word_q, word_d;
  logic [31:0]       word_nx;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bv;
  logic [7:0]        rx_byte;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  rx_byte_edge u_edge (
    .clk_i  (CLK),
    .rst_i  (RST),
    .data_i (rx_data),
    .level_i(rx_finished),
    .valid_o(bv),
    .byte_o (rx_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef UART_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    cnt_nx  = {cnt_q[23:0], rx_byte};
    word_nx = {word_q, rx_byte};
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          cnt_d   = '0;
          bcnt_d  = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      HDR: begin
        if (bv) begin
          cnt_d  = cnt_nx;
          bcnt_d = 2'(bcnt_q + 2'd1);
          if (bcnt_q == 2'(HDR_BYTES - 1)) begin
            if (cnt_nx == '0)                   state_d = END_STATE;
            else if (64'(cnt_nx) > MAX_WORDS)   state_d = ERR;
            else begin
              state_d = BODY;
              idx_d   = '0;
              bcnt_d  = '0;
            end
          end
        end
      end
      BODY: begin
        if (bv) begin
          word_d = word_nx[23:0];
          bcnt_d = 2'(bcnt_q + 2'd1);
`ifdef UART_LOADER_CHECKSUM_EN
          sum_d  = sum_q ^ rx_byte;
`endif
          // The strobe is registered, so it lands the cycle after the 4th byte.
          if (bcnt_q == 2'(BYTES_PER_WORD - 1)) begin
            we_d    = 1'b1;
            wdata_d = word_nx;
            addr_d  = START_ADDR + idx_q[ADDR_W-1:0];
            idx_d   = idx_q + 32'd1;
            if (idx_q == cnt_q - 32'd1) state_d = END_STATE;
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHK: begin
        if (bv) state_d = (rx_byte == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= START_ADDR;
      wdata_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == HDR) || (state_q == BODY) || (state_q == CHK);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);

endmodule
